fp_minmax_tracker: RTL and testbench
====================================

# fp_minmax_tracker

Streaming half-precision min/max tracker. Accepts a frame of 16-bit FP samples over a valid/ready handshake and sequences each sample through the ALU's half-precision comparator, one compare per cycle. It drives the comparator's x/y operands and consumes its negative/zero flags, so it sits both upstream and downstream of the comparator. At end of frame it presents the frame minimum, maximum and sample count.

## Interface
- `COUNT_W`, default 16: width of the sample counter. The counter saturates at 2^COUNT_W-1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  sample valid.
- `in_data`  in  16  half-precision sample: sign[15], exp[14:10], mant[9:0].
- `in_last`  in  1  marks the final sample of a frame.
- `in_ready`  out  1  tracker can accept a sample.
- `cmp_x`  out  16  comparator operand x (the current sample).
- `cmp_y`  out  16  comparator operand y (the running min or max).
- `cmp_negative`  in  1  comparator flag: x < y.
- `cmp_zero`  in  1  comparator flag: x == y.
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_min`  out  16  frame minimum.
- `out_max`  out  16  frame maximum.
- `out_count`  out  COUNT_W  samples accumulated in the frame.
- `out_nan`  out  1  at least one NaN was seen in the frame (only when NaN filtering is enabled; otherwise tied to 0).

## Operation
- **State machine.** States are IDLE, ACCEPT, CMP_MIN, CMP_MAX, DONE.
- **IDLE.** `in_ready`=1.
  - On handshake: min_reg and max_reg load `in_data`; count loads 1.
  - If `in_last`, go to DONE; otherwise go to ACCEPT.
- **ACCEPT.** `in_ready`=1.
  - On handshake: latch `in_data` into sample_reg and `in_last` into last_reg.
  - Increment count (saturating), then go to CMP_MIN.
- **CMP_MIN.** `in_ready`=0.
  - Drive `cmp_x`=sample_reg and `cmp_y`=min_reg.
  - If `cmp_negative`=1, min_reg loads sample_reg.
  - Go to CMP_MAX.
- **CMP_MAX.** `in_ready`=0.
  - Drive `cmp_y`=max_reg.
  - If `cmp_negative`=0 and `cmp_zero`=0, max_reg loads sample_reg.
  - If last_reg, go to DONE; otherwise go to ACCEPT.
- **DONE.** `out_valid`=1, with `out_min`/`out_max`/`out_count`/`out_nan` held stable.
  - On `out_ready`, go to IDLE. The next frame's first sample is not accepted in the same cycle.
- **Operand muxing.** `cmp_x`=sample_reg always. `cmp_y`=max_reg in CMP_MAX and min_reg in every other state.
- **Ordering.** Ordering is exactly the comparator's ordering, so +0 (0x0000) ranks above -0 (0x8000).
- **Ties.** Equal values never update min_reg or max_reg.
- **Stall behaviour.** `in_data` is ignored whenever `in_ready`=0. An asserted `in_valid` is held by the producer until the handshake completes.

## Timing
- **Reset values.** During and after reset: state=IDLE; `out_valid`=0; `out_min`, `out_max`, `out_count`, `out_nan`, sample_reg and last_reg are all 0. `cmp_x`=`cmp_y`=0.
  - `in_ready` is 0 while `reset`=1 and 1 in the first cycle after release.
- **Comparator path.** The comparator is purely combinational: `cmp_negative`/`cmp_zero` are sampled in the same cycle that `cmp_x`/`cmp_y` are driven from registers.
- **Throughput.**
  - First sample of a frame: 1 cycle.
  - Each later sample: 3 cycles (ACCEPT, CMP_MIN, CMP_MAX).
- **Latency.** `out_valid` rises in the cycle after CMP_MAX of the last sample, or the cycle after the IDLE handshake for a single-sample frame.
- **Count saturation.** At 2^COUNT_W-1, count holds. min/max tracking continues unaffected.
- **Reset mid-frame or in DONE.** The partial frame is discarded and no result is emitted.
- **Back-to-back frames.** There is at least one IDLE cycle between DONE and the next frame start.

## Configuration
- **`FP_MINMAX_NAN_FILTER_EN` defined.**
  - Samples with exp=5'h1F and mant≠0 are NaN.
  - In ACCEPT, a NaN is consumed (handshake completes) but not compared, and count is not incremented. `out_nan` is set sticky for the frame.
  - If the NaN carries `in_last`, go straight to DONE.
  - A NaN as the first sample (IDLE) sets `out_nan` and stays in IDLE, so the frame starts at the next non-NaN sample. If that NaN carries `in_last`, go to DONE with count=0, min=max=0.
  - `out_nan` clears on entry to IDLE from DONE.
- **`FP_MINMAX_NAN_FILTER_EN` undefined.** NaNs are compared as ordinary bit patterns and `out_nan` is constant 0.

## Test plan
- Frame 0x3C00, 0x4000, 0xC200, 0x3800 (1.0, 2.0, -3.0, 0.5; last on 0x3800) -> min=0xC200, max=0x4000, count=4; `out_valid` asserted 11 cycles after the first handshake.
- Single sample 0xB800 with `in_last` -> next cycle `out_valid`=1, min=max=0xB800, count=1.
- Frame 0x0000, 0x8000, 0x0000 -> min=0x8000, max=0x0000; the tie never updates.
- `out_ready` held 0 for 5 cycles in DONE -> outputs stable and `in_ready`=0; release returns to IDLE, and a following frame of 0x7C00 gives max=min=0x7C00.
- `reset` pulsed during CMP_MIN of the 2nd sample -> all outputs 0, no `out_valid`; a fresh frame afterwards is correct.
- With `FP_MINMAX_NAN_FILTER_EN`: frame 0x3C00, 0x7E00, 0x4000 -> min=0x3C00, max=0x4000, count=2, `out_nan`=1. Without the macro the same frame gives max=0x7E00, count=3.

Source files
------------

// File: rtl/fp_minmax_tracker.sv
// Streaming half-precision min/max tracker driving an external combinational comparator.
// Optional NaN filtering is enabled by defining FP_MINMAX_NAN_FILTER_EN.
module fp_minmax_tracker #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [15:0]        in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic [15:0]        cmp_x,
  output logic [15:0]        cmp_y,
  input  logic               cmp_negative,
  input  logic               cmp_zero,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        out_min,
  output logic [15:0]        out_max,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_nan
);

  typedef enum logic [2:0] {IDLE, ACCEPT, CMP_MIN, CMP_MAX, DONE} state_t;

  state_t             state_q, state_d;
  logic [15:0]        min_q, min_d, max_q, max_d, sample_q, sample_d;
  logic               last_q, last_d, nan_q, nan_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               in_hs, is_nan;

`ifdef FP_MINMAX_NAN_FILTER_EN
  assign is_nan = (in_data[14:10] == 5'h1F) && (in_data[9:0] != 10'd0);
`else
  assign is_nan = 1'b0;
`endif

  assign in_ready  = !reset && (state_q == IDLE || state_q == ACCEPT);
  assign in_hs     = in_valid && in_ready;
  assign cmp_x     = sample_q;
  assign cmp_y     = (state_q == CMP_MAX) ? max_q : min_q;
  assign out_valid = (state_q == DONE);
  assign out_min   = min_q;
  assign out_max   = max_q;
  assign out_count = count_q;
  assign out_nan   = nan_q;

  always_comb begin
    state_d  = state_q;
    min_d    = min_q;
    max_d    = max_q;
    sample_d = sample_q;
    last_d   = last_q;
    nan_d    = nan_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (in_hs) begin
          if (is_nan) begin
            // a leading NaN does not open the frame; a lone NaN frame reports empty
            nan_d = 1'b1;
            if (in_last) begin
              min_d   = '0;
              max_d   = '0;
              count_d = '0;
              state_d = DONE;
            end
          end else begin
            min_d   = in_data;
            max_d   = in_data;
            count_d = COUNT_W'(1);
            state_d = in_last ? DONE : ACCEPT;
          end
        end
      end
      ACCEPT: begin
        if (in_hs) begin
          if (is_nan) begin
            nan_d = 1'b1;
            if (in_last) state_d = DONE;
          end else begin
            sample_d = in_data;
            last_d   = in_last;
            count_d  = (count_q == {COUNT_W{1'b1}}) ? count_q : count_q + 1'b1;
            state_d  = CMP_MIN;
          end
        end
      end
      CMP_MIN: begin
        if (cmp_negative) min_d = sample_q;
        state_d = CMP_MAX;
      end
      CMP_MAX: begin
        if (!cmp_negative && !cmp_zero) max_d = sample_q;
        state_d = last_q ? DONE : ACCEPT;
      end
      DONE: begin
        if (out_ready) begin
          nan_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      min_q    <= '0;
      max_q    <= '0;
      sample_q <= '0;
      last_q   <= 1'b0;
      nan_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      min_q    <= min_d;
      max_q    <= max_d;
      sample_q <= sample_d;
      last_q   <= last_d;
      nan_q    <= nan_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_fp_minmax_tracker.sv
// Bench for fp_minmax_tracker with a behavioural half-precision comparator.
// Expectations follow FP_MINMAX_NAN_FILTER_EN when it is defined for the build.
module tb_fp_minmax_tracker;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_last, in_ready, out_valid, out_ready, out_nan;
  logic [15:0]   in_data, cmp_x, cmp_y, out_min, out_max;
  logic          cmp_negative, cmp_zero;
  logic [CW-1:0] out_count;
  int            cyc = 0, total = 0, bad = 0, first_h = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_minmax_tracker #(.COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .cmp_x(cmp_x), .cmp_y(cmp_y), .cmp_negative(cmp_negative),
    .cmp_zero(cmp_zero), .out_valid(out_valid), .out_ready(out_ready), .out_min(out_min),
    .out_max(out_max), .out_count(out_count), .out_nan(out_nan));

  // sign-magnitude to monotonic unsigned key: -0 sorts just below +0
  function automatic logic [15:0] fkey(input logic [15:0] v);
    return v[15] ? ~v : (v | 16'h8000);
  endfunction
  assign cmp_negative = fkey(cmp_x) < fkey(cmp_y);
  assign cmp_zero     = (cmp_x == cmp_y);

  typedef struct packed {
    logic [4:0]  first;
    logic [3:0]  n;
    logic [15:0] emin, emax;
    logic [2:0]  ecnt;
    logic        enan;
    logic [5:0]  elat;   // cycle of out_valid, counting the first handshake cycle as 1
  } vec_t;

  logic [15:0] pool [24];
  vec_t        vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // called at a negedge; returns at the negedge following the handshake edge
  task automatic send(input logic [15:0] d, input logic l, input logic first);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (!in_ready) chk("hs_timeout", 0, 1);
    if (first) first_h = cyc;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; in_data = 16'hDEAD; in_last = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    int t = 0;
    while (!out_valid && t < 200) begin @(negedge clk); t++; end
    if (!out_valid) chk("done_timeout", 0, 1);
    lat = cyc - first_h + 1;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk("idle_out_valid", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);
  endtask

  task automatic run_frame(input int k);
    int lat;
    vec_t v = vecs[k];
    for (int i = 0; i < int'(v.n); i++)
      send(pool[int'(v.first) + i], i == int'(v.n) - 1, i == 0);
    wait_done(lat);
    chk($sformatf("v%0d_min", k), out_min, v.emin);
    chk($sformatf("v%0d_max", k), out_max, v.emax);
    chk($sformatf("v%0d_count", k), out_count, v.ecnt);
    chk($sformatf("v%0d_nan", k), out_nan, v.enan);
    chk($sformatf("v%0d_valid_cycle", k), lat, v.elat);
    release_result();
  endtask

  initial begin
    int lat;
    pool = '{16'h3C00, 16'h4000, 16'hC200, 16'h3800, 16'hB800, 16'h0000, 16'h8000, 16'h0000,
             16'h7C00, 16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'hBC00, 16'h4500, 16'h3800,
             16'hC000, 16'h3400, 16'h3C00, 16'h7E00, 16'h4000, 16'h7E00, 16'h3C00, 16'h7E00};
    vecs[0] = '{5'd0,  4'd4, 16'hC200, 16'h4000, 3'd4, 1'b0, 6'd11};
    vecs[1] = '{5'd4,  4'd1, 16'hB800, 16'hB800, 3'd1, 1'b0, 6'd2};
    vecs[2] = '{5'd5,  4'd3, 16'h8000, 16'h0000, 3'd3, 1'b0, 6'd8};
    vecs[3] = '{5'd8,  4'd1, 16'h7C00, 16'h7C00, 3'd1, 1'b0, 6'd2};
    vecs[4] = '{5'd9,  4'd9, 16'hC000, 16'h4500, 3'd7, 1'b0, 6'd26};  // count saturates at 7
`ifdef FP_MINMAX_NAN_FILTER_EN
    vecs[5] = '{5'd18, 4'd3, 16'h3C00, 16'h4000, 3'd2, 1'b1, 6'd6};
    vecs[6] = '{5'd21, 4'd2, 16'h3C00, 16'h3C00, 3'd1, 1'b1, 6'd3};
    vecs[7] = '{5'd23, 4'd1, 16'h0000, 16'h0000, 3'd0, 1'b1, 6'd2};
`else
    vecs[5] = '{5'd18, 4'd3, 16'h3C00, 16'h7E00, 3'd3, 1'b0, 6'd8};
    vecs[6] = '{5'd21, 4'd2, 16'h3C00, 16'h7E00, 3'd2, 1'b0, 6'd5};
    vecs[7] = '{5'd23, 4'd1, 16'h7E00, 16'h7E00, 3'd1, 1'b0, 6'd2};
`endif
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outs", {out_min, out_max}, 0);
    chk("rst_count_nan", {out_count, out_nan}, 0);
    chk("rst_cmp", {cmp_x, cmp_y}, 0);
    reset = 1'b0; #1;
    chk("post_rst_in_ready", in_ready, 1);
    @(negedge clk);

    for (int k = 0; k < 8; k++) run_frame(k);

    // operand muxing across CMP_MIN/CMP_MAX, then a held-off result
    send(16'h3C00, 1'b0, 1'b1);
    send(16'h4000, 1'b0, 1'b0);
    send(16'h3800, 1'b1, 1'b0);
    chk("cmpmin_x", cmp_x, 16'h3800);
    chk("cmpmin_y", cmp_y, 16'h3C00);
    @(negedge clk);
    chk("cmpmax_y", cmp_y, 16'h4000);
    wait_done(lat);
    in_valid = 1'b1; in_data = 16'hFFFF; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_result", {out_min, out_max, 13'd0, out_count}, {16'h3800, 16'h4000, 16'd3});
      chk("stall_nan_cleared", out_nan, 0);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    release_result();
    run_frame(3);

    // reset during CMP_MIN of the second sample
    send(16'h3C00, 1'b0, 1'b1);
    send(16'hC000, 1'b0, 1'b0);
    chk("mid_cmp_x", cmp_x, 16'hC000);
    reset = 1'b1; #1;
    chk("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b0; #1;
    chk("mid_rst_outs", {out_min, out_max, cmp_x, cmp_y}, 0);
    chk("mid_rst_count", {out_count, out_nan}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_no_valid", out_valid, 0);
    end
    run_frame(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
